// File: rtl/eeprom_rx_fifo.sv
// Receive FIFO for the CM811 EEPROM controller: serial engine writes, host drains.
// Define EEPROM_RX_FIFO_PARITY_EN to store and check an even-parity bit per word.
module eeprom_rx_fifo #(
  parameter int WIDTH      = 8,
  parameter int DEPTH      = 128,
  parameter int AFULL_LVL  = 120,
  parameter int AEMPTY_LVL = 8,
  parameter int PIPE       = 1,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic             CLOCK,
  input  logic             RESET_N,
  input  logic             WEN,
  input  logic [WIDTH-1:0] WDATA,
  input  logic             REN,
  output logic [WIDTH-1:0] RDATA,
  output logic             RVALID,
  output logic             FULL,
  output logic             EMPTY,
  output logic             AFULL,
  output logic             AEMPTY,
  output logic [AW:0]      COUNT,
  output logic             OVERFLOW,
  output logic             UNDERFLOW,
  output logic             PERR
);

`ifdef EEPROM_RX_FIFO_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  localparam logic [AW:0] FULL_CNT   = (AW+1)'(DEPTH);
  localparam logic [AW:0] AFULL_CNT  = (AW+1)'(AFULL_LVL);
  localparam logic [AW:0] AEMPTY_CNT = (AW+1)'(AEMPTY_LVL);

  logic [MW-1:0]    mem [DEPTH];
  logic [AW-1:0]    wptr, rptr;
  logic [AW:0]      count_q, count_next;
  logic             read_accept, write_accept;
  logic [MW-1:0]    wr_word, rd_word;
  logic [WIDTH-1:0] s1_data;
  logic             s1_valid;

  assign read_accept  = REN & ~EMPTY;
  assign write_accept = WEN & (~FULL | read_accept);

`ifdef EEPROM_RX_FIFO_PARITY_EN
  assign wr_word = {^WDATA, WDATA};
`else
  assign wr_word = WDATA;
`endif

  always_comb begin
    count_next = count_q;
    case ({write_accept, read_accept})
      2'b10:   count_next = count_q + (AW+1)'(1);
      2'b01:   count_next = count_q - (AW+1)'(1);
      default: count_next = count_q;
    endcase
  end

  // NOTE: the storage array has no reset branch; clearing it would turn the
  // inferred RAM into flops and nothing depends on its contents after reset.
  always_ff @(posedge CLOCK) begin
    if (RESET_N && write_accept) mem[wptr] <= wr_word;
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register sees pre-edge values, independent of statement order.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      wptr      <= '0;
      rptr      <= '0;
      count_q   <= '0;
      FULL      <= 1'b0;
      EMPTY     <= 1'b1;
      AFULL     <= 1'b0;
      AEMPTY    <= 1'b1;
      OVERFLOW  <= 1'b0;
      UNDERFLOW <= 1'b0;
    end else begin
      if (write_accept) wptr <= wptr + 1'b1;
      if (read_accept)  rptr <= rptr + 1'b1;
      count_q   <= count_next;
      FULL      <= (count_next == FULL_CNT);
      EMPTY     <= (count_next == '0);
      AFULL     <= (count_next >= AFULL_CNT);
      AEMPTY    <= (count_next <= AEMPTY_CNT);
      OVERFLOW  <= WEN & ~write_accept;
      UNDERFLOW <= REN & EMPTY;
    end
  end

  assign COUNT   = count_q;
  assign rd_word = mem[rptr];

  // First read stage: the array fetch. Data holds between reads.
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
    end else begin
      s1_valid <= read_accept;
      if (read_accept) s1_data <= rd_word[WIDTH-1:0];
    end
  end

`ifdef EEPROM_RX_FIFO_PARITY_EN
  logic s1_perr;
  always_ff @(posedge CLOCK) begin
    if (!RESET_N) s1_perr <= 1'b0;
    else          s1_perr <= read_accept & (^rd_word);
  end
`endif

  generate
    if (PIPE != 0) begin : g_pipe
      logic [WIDTH-1:0] s2_data;
      logic             s2_valid;
      always_ff @(posedge CLOCK) begin
        if (!RESET_N) begin
          s2_valid <= 1'b0;
          s2_data  <= '0;
        end else begin
          s2_valid <= s1_valid;
          if (s1_valid) s2_data <= s1_data;
        end
      end
      assign RDATA  = s2_data;
      assign RVALID = s2_valid;
`ifdef EEPROM_RX_FIFO_PARITY_EN
      logic s2_perr;
      always_ff @(posedge CLOCK) begin
        if (!RESET_N) s2_perr <= 1'b0;
        else          s2_perr <= s1_perr;
      end
      assign PERR = s2_perr;
`else
      assign PERR = 1'b0;
`endif
    end else begin : g_nopipe
      assign RDATA  = s1_data;
      assign RVALID = s1_valid;
`ifdef EEPROM_RX_FIFO_PARITY_EN
      assign PERR = s1_perr;
`else
      assign PERR = 1'b0;
`endif
    end
  endgenerate

endmodule

// File: tb/tb_eeprom_rx_fifo.sv
// Directed bench for eeprom_rx_fifo: a queue model predicts data order, flags,
// pulses and read latency; returned words are popped from a scoreboard.
module tb_eeprom_rx_fifo;
  localparam int WIDTH = 8;
  localparam int DEPTH = 128;
  localparam int AFULL_LVL = 120;
  localparam int AEMPTY_LVL = 8;
  localparam int PIPE = 1;
  localparam int AW = $clog2(DEPTH);

  logic             CLOCK = 1'b0;
  logic             RESET_N, WEN, REN;
  logic [WIDTH-1:0] WDATA, RDATA;
  logic             RVALID, FULL, EMPTY, AFULL, AEMPTY, OVERFLOW, UNDERFLOW, PERR;
  logic [AW:0]      COUNT;

  eeprom_rx_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_LVL(AFULL_LVL),
    .AEMPTY_LVL(AEMPTY_LVL), .PIPE(PIPE)
  ) dut (
    .CLOCK(CLOCK), .RESET_N(RESET_N), .WEN(WEN), .WDATA(WDATA), .REN(REN),
    .RDATA(RDATA), .RVALID(RVALID), .FULL(FULL), .EMPTY(EMPTY), .AFULL(AFULL),
    .AEMPTY(AEMPTY), .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW),
    .PERR(PERR)
  );

  always #5 CLOCK = ~CLOCK;

  int checks = 0;
  int errors = 0;

  // Entry bit 8 marks a word whose stored copy was corrupted on purpose.
  logic [8:0] model_q[$];
  logic [8:0] exp_q[$];
  logic       pv1 = 1'b0, pv2 = 1'b0;
  logic       exp_ovf, exp_unf;
  int         m_rptr = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive at the falling edge, advance the model, sample at the next falling edge.
  task automatic cycle(input logic wen, input logic [7:0] wd, input logic ren, input logic rst_n);
    logic       ra, wa, exp_v;
    logic [8:0] ent;
    int         sz;
    RESET_N = rst_n; WEN = wen; WDATA = wd; REN = ren;
    sz = model_q.size();
    if (!rst_n) begin
      model_q.delete(); exp_q.delete();
      pv1 = 1'b0; pv2 = 1'b0; m_rptr = 0;
      exp_ovf = 1'b0; exp_unf = 1'b0;
    end else begin
      ra = ren && (sz != 0);
      wa = wen && ((sz < DEPTH) || ra);
      exp_ovf = wen && !wa;
      exp_unf = ren && (sz == 0);
      pv2 = pv1; pv1 = ra;
      if (ra) begin
        exp_q.push_back(model_q.pop_front());
        m_rptr = (m_rptr + 1) % DEPTH;
      end
      if (wa) model_q.push_back({1'b0, wd});
    end
    @(posedge CLOCK);
    @(negedge CLOCK);
    exp_v = (PIPE != 0) ? pv2 : pv1;
    check("rvalid", {31'b0, RVALID}, {31'b0, exp_v});
    if (RVALID && exp_q.size() != 0) begin
      ent = exp_q.pop_front();
      check("rdata", {24'b0, RDATA}, {24'b0, ent[7:0]});
      check("perr", {31'b0, PERR}, {31'b0, ent[8]});
    end else begin
      check("perr_idle", {31'b0, PERR}, 32'd0);
    end
    sz = model_q.size();
    check("count", 32'(COUNT), sz);
    check("empty", {31'b0, EMPTY}, {31'b0, sz == 0});
    check("full", {31'b0, FULL}, {31'b0, sz == DEPTH});
    check("afull", {31'b0, AFULL}, {31'b0, sz >= AFULL_LVL});
    check("aempty", {31'b0, AEMPTY}, {31'b0, sz <= AEMPTY_LVL});
    check("overflow", {31'b0, OVERFLOW}, {31'b0, exp_ovf});
    check("underflow", {31'b0, UNDERFLOW}, {31'b0, exp_unf});
  endtask

  initial begin
    logic [8:0] ent;
    RESET_N = 1'b0; WEN = 1'b0; REN = 1'b0; WDATA = '0;

    // Reset state.
    cycle(0, 8'h00, 0, 0);
    cycle(0, 8'h00, 0, 0);
    check("reset_rdata", {24'b0, RDATA}, 32'd0);

    // Four writes then four back-to-back reads; RVALID lands two cycles after first REN.
    for (int i = 0; i < 4; i++) cycle(1, 8'h11 + 8'(i), 0, 1);
    for (int i = 0; i < 4; i++) cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);
    check("empty_after_drain", {31'b0, EMPTY}, 32'd1);

    // Fill to full; AFULL rises after the 120th write.
    for (int i = 0; i < DEPTH; i++) cycle(1, 8'(i), 0, 1);
    check("full_count", 32'(COUNT), DEPTH);
    // Rejected write.
    cycle(1, 8'hEE, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Simultaneous read and write while full, long enough to wrap both pointers.
    for (int i = 0; i < 200; i++) cycle(1, 8'h80 + 8'(i), 1, 1);
    // Drain everything and confirm order.
    for (int i = 0; i < DEPTH; i++) cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Read while empty with a concurrent write: UNDERFLOW, write still lands.
    cycle(1, 8'hA5, 1, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);

    // Reset one edge after an accepted read squashes the pending word.
    cycle(1, 8'h5C, 0, 1);
    cycle(1, 8'h5D, 0, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 0);
    for (int i = 0; i < 3; i++) cycle(0, 8'h00, 0, 1);

`ifdef EEPROM_RX_FIFO_PARITY_EN
    // Corrupt one stored bit of the oldest word; only that word reports PERR.
    cycle(1, 8'h3C, 0, 1);
    cycle(1, 8'h5A, 0, 1);
    cycle(0, 8'h00, 0, 1);
    dut.mem[m_rptr][0] = ~dut.mem[m_rptr][0];
    ent = model_q[0];
    model_q[0] = {1'b1, ent[7:1], ~ent[0]};
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 1, 1);
    cycle(0, 8'h00, 0, 1);
    cycle(0, 8'h00, 0, 1);
`else
    ent = 9'h000;
`endif

    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
